// File: rtl/spi_reg_master_if.sv
// Request/response handshake between a register-access client and spi_reg_master.
interface spi_reg_master_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_rw;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/spi_reg_master.sv
// SPI initiator issuing single {inst, addr, data} register frames, MSB-first.
// Optional: SPI_REG_MASTER_MISO_SYNC_EN adds a 2-flop synchroniser on miso_i.
module spi_reg_master #(
    parameter int CLK_DIV    = 4,
    parameter int INST_WIDTH = 1,
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int CS_GAP     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_reg_master_if.slave     bus,
    output logic                sck_o,
    output logic                mosi_o,
    output logic                cs_n_o,
    input  logic                miso_i
);
    localparam int FRAME  = INST_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int EDGE_W = $clog2(2 * FRAME + 1);
    localparam int GAP_W  = $clog2(CS_GAP + 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t                state;
    logic [DIV_W-1:0]      div;
    logic [EDGE_W-1:0]     edges;
    logic [GAP_W-1:0]      gap;
    logic [FRAME-2:0]      tx;
    logic [DATA_WIDTH-1:0] rx;
    logic                  ready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [FRAME-1:0]      frame_in;
    logic                  miso_smp;
    logic                  tick;

    if (CLK_DIV < 2) begin : g_div_min
        $error("spi_reg_master: CLK_DIV must be >= 2");
    end

`ifdef SPI_REG_MASTER_MISO_SYNC_EN
    logic [1:0] miso_sync;

    if (CLK_DIV < 3) begin : g_div_sync
        $error("spi_reg_master: CLK_DIV must be >= 3 with the miso synchroniser");
    end

    always_ff @(posedge clk) begin
        if (!rst_n) miso_sync <= '0;
        else        miso_sync <= {miso_sync[0], miso_i};
    end
    assign miso_smp = miso_sync[1];
`else
    assign miso_smp = miso_i;
`endif

    assign frame_in      = {INST_WIDTH'(bus.req_rw), bus.req_addr, bus.req_wdata};
    assign tick          = (div == DIV_W'(CLK_DIV - 1));
    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            div       <= '0;
            edges     <= '0;
            gap       <= '0;
            tx        <= '0;
            rx        <= '0;
            ready     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            sck_o     <= 1'b0;
            mosi_o    <= 1'b0;
            cs_n_o    <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            div       <= (state == IDLE || tick) ? '0 : div + 1'b1;
            case (state)
                IDLE: begin
                    ready <= 1'b1;
                    if (bus.req_valid && ready) begin
                        // MSB goes straight to mosi_o; tx keeps only the bits still to send
                        tx     <= frame_in[FRAME-2:0];
                        mosi_o <= frame_in[FRAME-1];
                        cs_n_o <= 1'b0;
                        ready  <= 1'b0;
                        edges  <= '0;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        sck_o <= 1'b1;
                        rx    <= {rx[DATA_WIDTH-2:0], miso_smp};
                        edges <= EDGE_W'(1);
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (tick) begin
                        sck_o <= ~sck_o;
                        edges <= edges + 1'b1;
                        if (!sck_o) begin
                            rx <= {rx[DATA_WIDTH-2:0], miso_smp};
                        end else if (edges == EDGE_W'(2 * FRAME - 1)) begin
                            state <= HOLD;
                        end else begin
                            mosi_o <= tx[FRAME-2];
                            tx     <= {tx[FRAME-3:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_n_o    <= 1'b1;
                        mosi_o    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rx;
                        gap       <= '0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    gap <= gap + 1'b1;
                    if (gap == GAP_W'(CS_GAP - 1)) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: cycle-level timing model plus directed frames with literal checks.
module tb_spi_reg_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic miso = 1'b0;
    logic sck, mosi, cs_n;

    spi_reg_master_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus ();

    spi_reg_master #(
        .CLK_DIV(4), .INST_WIDTH(1), .ADDR_WIDTH(7), .DATA_WIDTH(8), .CS_GAP(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .sck_o(sck), .mosi_o(mosi), .cs_n_o(cs_n), .miso_i(miso)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Timing model: a frame accepted in cycle acc holds cs_n low for cycles acc+1..acc+132,
    // each SCK half-period is 4 cycles, response at acc+133, ready again at acc+141.
    int         cyc = 0;
    bit         chk_en = 0;
    bit         active = 0;
    int         acc = 0;
    int         post_rst = -1;
    logic [15:0] mframe = '0;
    logic [7:0]  m_sb = '0;
    logic [7:0]  exp_rd = '0;
    logic [7:0]  sb = '0;

    function automatic bit exp_ready(input int c);
        if (c == post_rst) return 1'b0;
        if (active && c <= acc + 140) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            active   = 0;
            post_rst = cyc + 1;
            exp_rd   = '0;
            chk_en   = 1;
        end else if (chk_en && bus.req_valid === 1'b1 && exp_ready(cyc)) begin
            active = 1;
            acc    = cyc;
            mframe = {bus.req_rw, bus.req_addr, bus.req_wdata};
            m_sb   = sb;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic e_cs, e_sck, e_mosi, e_rv;
            int k, ph;
            e_cs = 1'b1; e_sck = 1'b0; e_mosi = 1'b0; e_rv = 1'b0;
            if (active && cyc >= acc + 1 && cyc <= acc + 132) begin
                k = cyc - acc - 1;
                ph = k / 4;
                e_cs = 1'b0;
                e_sck = ph[0];
                e_mosi = (ph < 32) ? mframe[15 - ph / 2] : mframe[0];
            end
            if (active && cyc == acc + 133) begin
                e_rv = 1'b1;
                exp_rd = m_sb;
            end
            check($sformatf("outputs@%0d {ready,cs_n,sck,mosi,rsp_valid,rdata}", cyc),
                  {bus.req_ready, cs_n, sck, mosi, bus.rsp_valid, bus.rsp_rdata},
                  {exp_ready(cyc), e_cs, e_sck, e_mosi, e_rv, exp_rd});
        end
    end

    // Slave model: changes miso only while sck is low; data phase returns sb MSB-first.
    int          rcnt = 0;
    int          frames = 0;
    int          cs_low_len = 0;
    int          last_len = 0;
    int          cs_high_start = 0;
    int          last_gap = 0;
    int          last_rise = 0;
    int          period = 0;
    logic        sck_prev = 1'b0;
    logic        cs_prev = 1'b1;
    logic [15:0] cap = '0;
    logic [15:0] last_frame = '0;

    always @(negedge clk) begin
        if (cs_n !== 1'b0) rcnt = 0;
        if (sck === 1'b1 && sck_prev === 1'b0) begin
            rcnt++;
            cap = {cap[14:0], mosi};
            period = cyc - last_rise;
            last_rise = cyc;
        end
        if (cs_n === 1'b0) begin
            if (cs_prev !== 1'b0) begin
                cs_low_len = 0;
                last_gap = cyc - cs_high_start;
            end
            cs_low_len++;
        end else if (cs_prev === 1'b0) begin
            last_frame = cap;
            last_len = cs_low_len;
            cs_high_start = cyc;
            frames++;
        end
        if (sck === 1'b0) miso = (rcnt >= 8 && rcnt < 16) ? sb[15 - rcnt] : 1'b0;
        sck_prev = sck;
        cs_prev = cs_n;
    end

    // Must be called at a negedge; returns at the negedge after acceptance.
    task automatic send(input bit rw, input logic [6:0] a, input logic [7:0] d,
                        input bit keep, output int acc_c);
        bit ok;
        ok = 0;
        acc_c = -1;
        bus.req_valid = 1'b1;
        bus.req_rw = rw;
        bus.req_addr = a;
        bus.req_wdata = d;
        for (int n = 0; n < 2000 && !ok; n++) begin
            if (bus.req_ready === 1'b1) begin
                ok = 1;
                acc_c = cyc;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: req_ready stayed %0b, expected 1", bus.req_ready);
        end
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int rc, output logic [7:0] rd);
        bit found;
        found = 0;
        rc = -1;
        rd = 'x;
        for (int n = 0; n < 400 && !found; n++) begin
            if (bus.rsp_valid === 1'b1) begin
                found = 1;
                rc = cyc;
                rd = bus.rsp_rdata;
            end else begin
                @(negedge clk);
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: rsp_valid stayed %0b, expected 1", bus.rsp_valid);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, rc, f0, nrsp;
        logic [7:0] rd;
        bus.req_valid = 1'b0;
        bus.req_rw = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;

        repeat (3) @(negedge clk);
        check("reset_state", {bus.req_ready, cs_n, sck, mosi, bus.rsp_valid, bus.rsp_rdata},
              {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", bus.req_ready, 1'b1);

        // Write addr 5 data 0x01; slave returns 0x3c in the data phase
        sb = 8'h3c;
        send(1'b0, 7'd5, 8'h01, 1'b0, a1);
        wait_rsp(rc, rd);
        check("write_rsp_latency", rc - a1, 133);
        check("write_rsp_rdata", rd, 8'h3c);
        repeat (12) @(negedge clk);
        check("write_frame", last_frame, 16'h0501);
        check("write_cs_low", last_len, 132);
        check("sck_period", period, 8);

        // Read addr 0, slave 0xfb
        sb = 8'hfb;
        send(1'b1, 7'd0, 8'h00, 1'b0, a1);
        wait_rsp(rc, rd);
        check("read_rdata", rd, 8'hfb);
        repeat (12) @(negedge clk);
        check("read_frame", last_frame, 16'h8000);

        // Back-to-back writes with req_valid held
        sb = 8'h00;
        send(1'b0, 7'd8, 8'hff, 1'b1, a1);
        send(1'b0, 7'd8, 8'h20, 1'b0, a2);
        check("b2b_accept_spacing", a2 - a1, 141);
        check("b2b_frame1", last_frame, 16'h08ff);
        check("b2b_gap_ge_cs_gap", last_gap >= 8, 1'b1);
        wait_rsp(rc, rd);
        repeat (12) @(negedge clk);
        check("b2b_frame2", last_frame, 16'h0820);

        // Request pulsed during XFER must be dropped
        f0 = frames;
        send(1'b0, 7'h12, 8'h34, 1'b0, a1);
        repeat (60) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr = 7'd3;
        bus.req_wdata = 8'h77;
        repeat (2) @(negedge clk);
        bus.req_valid = 1'b0;
        wait_rsp(rc, rd);
        repeat (150) @(negedge clk);
        check("busy_frame_unchanged", last_frame, 16'h1234);
        check("busy_no_extra_frame", frames - f0, 1);

        // Reset for one cycle right after SCK edge 10
        send(1'b0, 7'h2a, 8'h55, 1'b0, a1);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_pins", {cs_n, sck, mosi}, 3'b100);
        nrsp = 0;
        for (int n = 0; n < 200; n++) begin
            if (bus.rsp_valid === 1'b1) nrsp++;
            @(negedge clk);
        end
        check("midreset_no_rsp", nrsp, 0);
        sb = 8'hff;
        send(1'b1, 7'd0, 8'h00, 1'b0, a1);
        wait_rsp(rc, rd);
        check("post_reset_read", rd, 8'hff);
        repeat (12) @(negedge clk);
        check("post_reset_frame", last_frame, 16'h8000);

        // Read with alternating data pattern
        sb = 8'ha5;
        send(1'b1, 7'h7f, 8'h00, 1'b0, a1);
        wait_rsp(rc, rd);
        check("read_a5", rd, 8'ha5);
        repeat (12) @(negedge clk);
        check("read_a5_frame", last_frame, 16'hff00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
